// File: rtl/spi_txn_arbiter_if.sv
// rtl/spi_txn_arbiter_if.sv - APB-style access port between the arbiter and the SPI controller
interface spi_txn_arbiter_if;
  logic [7:0] m_paddr_o;
  logic [7:0] m_pwdata_o;
  logic       m_pwrite_o;
  logic       m_penable_o;
  logic [7:0] m_prdata_i;
  logic       m_pready_i;

  modport master (
    output m_paddr_o, m_pwdata_o, m_pwrite_o, m_penable_o,
    input  m_prdata_i, m_pready_i
  );

  modport slave (
    input  m_paddr_o, m_pwdata_o, m_pwrite_o, m_penable_o,
    output m_prdata_i, m_pready_i
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter running addr/data/ctrl writes and status polling on an SPI controller
module spi_txn_arbiter #(
  parameter int         NUM_REQ   = 2,
  parameter int         POLL_MAX  = 64,
  parameter logic [7:0] CTRL_ADDR = 8'h20
) (
  input  logic                 pclk_i,
  input  logic                 prst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] addr_i,
  input  logic [8*NUM_REQ-1:0] data_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [NUM_REQ-1:0]   err_o,
  output logic                 busy_o,
  spi_txn_arbiter_if.master    apb
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [7:0] ADDR_REG = 8'h00;
  localparam logic [7:0] DATA_REG = 8'h10;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_CTRL, POLL, GAP, FIN} state_t;

  state_t             state_q, ret_q;
  logic [IW-1:0]      ptr_q;
  logic [NUM_REQ-1:0] gnt_q, done_q, err_q;
  logic               busy_q;
  logic [7:0]         addr_q, data_q;
  logic [PW-1:0]      poll_cnt_q;
  logic [7:0]         paddr_q, pwdata_q;
  logic               pwrite_q, penable_q;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 found_d;
  logic [IW:0]          sum_d;
  logic [IW-1:0]        sel_d, ptr_d;
  logic [7:0]           sel_addr_d, sel_data_d;
  logic [PW-1:0]        poll_cnt_d;
  logic                 unused_prdata;

  // Rotate requests so bit 0 is the requester after the last grant, then take the first set bit.
  assign req_dbl = {req_i, req_i} >> ptr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    found_d = 1'b0;
    sum_d   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_d && req_rot[i]) begin
        found_d = 1'b1;
        sum_d   = {1'b0, ptr_q} + (IW+1)'(i);
      end
    end
    if (sum_d >= (IW+1)'(NUM_REQ)) begin
      sum_d = sum_d - (IW+1)'(NUM_REQ);
    end
    sel_d = sum_d[IW-1:0];
    ptr_d = (sel_d == IW'(NUM_REQ - 1)) ? '0 : sel_d + 1'b1;
  end

  always_comb begin
    sel_addr_d = '0;
    sel_data_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel_d == IW'(k)) begin
        sel_addr_d = addr_i[8*k +: 8];
        sel_data_d = data_i[8*k +: 8];
      end
    end
  end

  // Saturating so a long poll run can never wrap back under POLL_MAX.
  assign poll_cnt_d = (poll_cnt_q == PW'(POLL_MAX)) ? poll_cnt_q : poll_cnt_q + 1'b1;

  assign unused_prdata = ^apb.m_prdata_i[7:1];

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      poll_cnt_q <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      penable_q  <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q    <= WR_ADDR;
            gnt_q      <= NUM_REQ'(1) << sel_d;
            ptr_q      <= ptr_d;
            addr_q     <= sel_addr_d;
            data_q     <= sel_data_d;
            poll_cnt_q <= '0;
            busy_q     <= 1'b1;
            paddr_q    <= ADDR_REG;
            pwdata_q   <= sel_addr_d;
            pwrite_q   <= 1'b1;
            penable_q  <= 1'b1;
          end
        end
        WR_ADDR, WR_DATA, WR_CTRL: begin
          if (apb.m_pready_i) begin
            state_q   <= GAP;
            ret_q     <= (state_q == WR_ADDR) ? WR_DATA :
                         (state_q == WR_DATA) ? WR_CTRL : POLL;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
          end
        end
        POLL: begin
          if (apb.m_pready_i) begin
            poll_cnt_q <= poll_cnt_d;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            penable_q  <= 1'b0;
            if (!apb.m_prdata_i[0]) begin
              state_q <= FIN;
              done_q  <= gnt_q;
            end else if (poll_cnt_d >= PW'(POLL_MAX)) begin
              state_q <= FIN;
              err_q   <= gnt_q;
            end else begin
              state_q <= GAP;
              ret_q   <= POLL;
            end
          end
        end
        GAP: begin
          state_q   <= ret_q;
          penable_q <= 1'b1;
          case (ret_q)
            WR_DATA: begin
              paddr_q  <= DATA_REG;
              pwdata_q <= data_q;
              pwrite_q <= 1'b1;
            end
            WR_CTRL: begin
              paddr_q  <= CTRL_ADDR;
              pwdata_q <= 8'h01;
              pwrite_q <= 1'b1;
            end
            default: begin
              paddr_q  <= CTRL_ADDR;
              pwdata_q <= 8'h00;
              pwrite_q <= 1'b0;
            end
          endcase
        end
        FIN: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o           = gnt_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign busy_o          = busy_q;
  assign apb.m_paddr_o   = paddr_q;
  assign apb.m_pwdata_o  = pwdata_q;
  assign apb.m_pwrite_o  = pwrite_q;
  assign apb.m_penable_o = penable_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - directed scoreboard bench for spi_txn_arbiter
module tb_spi_txn_arbiter;
  localparam int NR = 2;
  localparam int PM = 4;

  logic            pclk = 1'b0;
  logic            prst = 1'b0;
  logic [NR-1:0]   req  = '0;
  logic [8*NR-1:0] addr = '0;
  logic [8*NR-1:0] data = '0;
  logic [NR-1:0]   gnt, done, err;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0]     acc_q[$];
  logic [2*NR-1:0] ev_q[$];
  logic [7:0]      rd_q[$];

  logic       stall_en   = 1'b0;
  logic [7:0] stall_addr = '0;
  logic [7:0] stall_data = '0;
  int         stall_max  = 0;
  int         stall_cnt  = 0;
  int         gap_len    = 0;
  logic       prev_cmp   = 1'b0;
  logic [16:0]     mon_acc;
  logic [2*NR-1:0] mon_ev;

  spi_txn_arbiter_if bus();

  spi_txn_arbiter #(
    .NUM_REQ  (NR),
    .POLL_MAX (PM),
    .CTRL_ADDR(8'h20)
  ) dut (
    .pclk_i (pclk),
    .prst_i (prst),
    .req_i  (req),
    .addr_i (addr),
    .data_i (data),
    .gnt_o  (gnt),
    .done_o (done),
    .err_o  (err),
    .busy_o (busy),
    .apb    (bus)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected access stream and completion event for one transaction of requester k.
  task automatic push_txn(input int k, input logic [7:0] a, input logic [7:0] d,
                          input int busy_reads, input logic [7:0] ok_val);
    int n_reads;
    logic [NR-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    n_reads = (busy_reads < PM) ? busy_reads + 1 : PM;
    acc_q.push_back({1'b1, 8'h00, a});
    acc_q.push_back({1'b1, 8'h10, d});
    acc_q.push_back({1'b1, 8'h20, 8'h01});
    for (int i = 0; i < n_reads; i++) begin
      acc_q.push_back({1'b0, 8'h20, 8'h00});
      rd_q.push_back((i < busy_reads) ? 8'h01 : ok_val);
    end
    ev_q.push_back((busy_reads < PM) ? {{NR{1'b0}}, oh} : {oh, {NR{1'b0}}});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_pulse"}, {done, err}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_bus"}, {bus.m_penable_o, bus.m_pwrite_o, bus.m_paddr_o, bus.m_pwdata_o}, 0);
  endtask

  task automatic wait_gnt(output int idle);
    idle = 0;
    while (gnt == '0 && idle < 200) begin
      idle++;
      @(negedge pclk);
    end
    check("gnt_timeout", idle < 200, 1);
  endtask

  task automatic wait_nogt();
    int n;
    n = 0;
    while (gnt != '0 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    check("nogt_timeout", n < 200, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((busy || acc_q.size() != 0 || ev_q.size() != 0) && n < 300) begin
      @(negedge pclk);
      n++;
    end
    check({tag, "_timeout"}, n < 300, 1);
    check({tag, "_acc_left"}, acc_q.size(), 0);
    check({tag, "_ev_left"}, ev_q.size(), 0);
  endtask

  // SPI controller model plus monitor: decides pready/prdata for the next edge and scores accesses.
  always @(negedge pclk) begin
    if (!prst) begin
      stall_cnt        = 0;
      gap_len          = 0;
      prev_cmp         = 1'b0;
      bus.m_pready_i   = 1'b0;
      bus.m_prdata_i   = 8'h00;
    end else begin
      if (prev_cmp) begin
        check("gap_idle", {bus.m_penable_o, bus.m_pwrite_o, bus.m_paddr_o, bus.m_pwdata_o}, 0);
      end
      if (!bus.m_penable_o) begin
        gap_len++;
      end else begin
        if (gap_len != 0 && !(bus.m_pwrite_o && bus.m_paddr_o == 8'h00)) begin
          check("gap_len", gap_len, 1);
        end
        gap_len = 0;
      end
      if (!stall_en) stall_cnt = 0;
      bus.m_pready_i = 1'b1;
      if (stall_en && bus.m_penable_o && bus.m_pwrite_o && bus.m_paddr_o == stall_addr &&
          stall_cnt < stall_max) begin
        check("stall_hold_wdata", bus.m_pwdata_o, stall_data);
        bus.m_pready_i = 1'b0;
        stall_cnt++;
      end
      if (bus.m_penable_o && !bus.m_pwrite_o) begin
        if (rd_q.size() > 0) bus.m_prdata_i = rd_q.pop_front();
        else bus.m_prdata_i = 8'h00;
      end
      prev_cmp = bus.m_penable_o && bus.m_pready_i;
      if (prev_cmp) begin
        check("acc_expected", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          mon_acc = acc_q.pop_front();
          check("acc", {bus.m_pwrite_o, bus.m_paddr_o, bus.m_pwdata_o}, mon_acc);
        end
      end
      if ((done | err) != '0) begin
        check("ev_expected", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) begin
          mon_ev = ev_q.pop_front();
          check("event", {err, done}, mon_ev);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle;
    int n;

    #12;
    check_zero("reset");
    @(negedge pclk);
    prst = 1'b1;

    // Both requesters held: grants alternate starting at requester 0.
    @(negedge pclk);
    #1;
    addr = {8'hB2, 8'hA1};
    data = {8'hD2, 8'hC1};
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) push_txn(0, 8'hA1, 8'hC1, 0, 8'h00);
      else            push_txn(1, 8'hB2, 8'hD2, 0, 8'h00);
    end
    req = 2'b11;
    @(negedge pclk);
    for (int g = 0; g < 4; g++) begin
      wait_gnt(idle);
      check("rr_gnt", gnt, (g % 2 == 0) ? 2'b01 : 2'b10);
      if (g == 0) check("rr_latency", idle, 0);
      else        check("rr_idle", idle, 1);
      if (g == 3) req = 2'b00;
      wait_nogt();
    end
    wait_drain("rr");

    // Single write/write/write/read transaction with immediate ready.
    @(negedge pclk);
    #1;
    addr = {8'h00, 8'h5A};
    data = {8'h00, 8'h3C};
    push_txn(0, 8'h5A, 8'h3C, 0, 8'h00);
    req = 2'b01;
    @(negedge pclk);
    wait_gnt(idle);
    check("basic_latency", idle, 0);
    check("basic_gnt", gnt, 2'b01);
    check("basic_busy", busy, 1);
    check("basic_first", {bus.m_penable_o, bus.m_pwrite_o, bus.m_paddr_o, bus.m_pwdata_o},
          {1'b1, 1'b1, 8'h00, 8'h5A});
    req = 2'b00;
    wait_drain("basic");

    // Ready withheld for five cycles on the data write.
    @(negedge pclk);
    #1;
    stall_en   = 1'b1;
    stall_addr = 8'h10;
    stall_data = 8'h77;
    stall_max  = 5;
    addr = {8'h00, 8'h66};
    data = {8'h00, 8'h77};
    push_txn(0, 8'h66, 8'h77, 0, 8'h00);
    req = 2'b01;
    @(negedge pclk);
    wait_gnt(idle);
    req = 2'b00;
    wait_drain("stall");
    check("stall_cycles", stall_cnt, 5);
    stall_en = 1'b0;

    // Poll timeout, last-chance success, and an early success ignoring upper status bits.
    for (int t = 0; t < 3; t++) begin
      @(negedge pclk);
      #1;
      addr = {8'h00, 8'h40 + 8'(t)};
      data = {8'h00, 8'h50 + 8'(t)};
      push_txn(0, 8'h40 + 8'(t), 8'h50 + 8'(t), (t == 0) ? PM : (t == 1) ? PM - 1 : 1, 8'hFE);
      req = 2'b01;
      @(negedge pclk);
      wait_gnt(idle);
      req = 2'b00;
      wait_drain("poll");
      check("poll_rd_left", rd_q.size(), 0);
    end

    // Request dropped and inputs changed mid-transaction: latched values still used.
    @(negedge pclk);
    #1;
    addr = {8'h00, 8'h9C};
    data = {8'h00, 8'hE7};
    push_txn(0, 8'h9C, 8'hE7, 0, 8'h00);
    req = 2'b01;
    @(negedge pclk);
    wait_gnt(idle);
    check("drop_gnt", gnt, 2'b01);
    req  = 2'b00;
    addr = {8'h00, 8'h11};
    data = {8'h00, 8'h22};
    wait_drain("drop");

    // Reset while the control write is pending: abandoned, then requester 1 wins first.
    @(negedge pclk);
    #1;
    stall_en   = 1'b1;
    stall_addr = 8'h20;
    stall_data = 8'h01;
    stall_max  = 1000;
    addr = {8'h00, 8'hAB};
    data = {8'h00, 8'hCD};
    acc_q.push_back({1'b1, 8'h00, 8'hAB});
    acc_q.push_back({1'b1, 8'h10, 8'hCD});
    req = 2'b01;
    @(negedge pclk);
    wait_gnt(idle);
    req = 2'b00;
    n = 0;
    while (!(bus.m_penable_o && bus.m_pwrite_o && bus.m_paddr_o == 8'h20) && n < 100) begin
      @(negedge pclk);
      n++;
    end
    check("rst_reach_ctrl", n < 100, 1);
    #1;
    prst = 1'b0;
    #1;
    check_zero("rst_async");
    stall_en = 1'b0;
    req  = 2'b10;
    addr = {8'h3E, 8'h00};
    data = {8'h4F, 8'h00};
    repeat (2) @(negedge pclk);
    check("rst_acc_left", acc_q.size(), 0);
    check("rst_ev_left", ev_q.size(), 0);
    #1;
    push_txn(1, 8'h3E, 8'h4F, 0, 8'h00);
    prst = 1'b1;
    @(negedge pclk);
    wait_gnt(idle);
    check("rst_latency", idle, 0);
    check("rst_gnt", gnt, 2'b10);
    req = 2'b00;
    wait_drain("rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requester ports, fixed round-robin arbitration among them.
REQ-002 Parameter POLL_MAX, default 64: maximum status reads per transaction before it is declared failed.
REQ-003 Parameter CTRL_ADDR, default 8'h20: controller control/status register address.
REQ-004 pclk_i  input  1  clock; all state changes on its rising edge.
REQ-005 prst_i  input  1  reset; asynchronous, active-low.
REQ-006 req_i  input  NUM_REQ  per-requester transaction request, level.
REQ-007 addr_i  input  8*NUM_REQ  per-requester SPI address byte; slice k belongs to requester k.
REQ-008 data_i  input  8*NUM_REQ  per-requester SPI data byte; slice k belongs to requester k.
REQ-009 gnt_o  output  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-010 done_o  output  NUM_REQ  one-cycle pulse: granted transaction completed.
REQ-011 err_o  output  NUM_REQ  one-cycle pulse: granted transaction timed out.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 m_paddr_o  output  8  APB address to the SPI controller.
REQ-014 m_pwdata_o  output  8  APB write data.
REQ-015 m_pwrite_o  output  1  1 = write, 0 = read.
REQ-016 m_penable_o  output  1  APB access strobe.
REQ-017 m_prdata_i  input  8  APB read data.
REQ-018 m_pready_i  input  1  APB transfer complete.

Function
REQ-019 States SHALL be IDLE, WR_ADDR, WR_DATA, WR_CTRL, POLL, GAP, FIN; sequence per grant: IDLE->WR_ADDR->GAP->WR_DATA->GAP->WR_CTRL->GAP->POLL->(GAP->POLL)*->FIN->IDLE.
REQ-020 In IDLE with any req_i bit high at a rising edge, the arbiter SHALL grant one requester, latch its addr/data slices, and drive the first access on the next cycle (1-cycle latency).
REQ-021 Grant SHALL be round-robin: search starts at (last granted + 1) mod NUM_REQ; after reset the search starts at requester 0.
REQ-022 WR_ADDR SHALL drive paddr 8'h00, pwdata = latched addr; WR_DATA SHALL drive paddr 8'h10, pwdata = latched data; WR_CTRL SHALL drive paddr CTRL_ADDR, pwdata 8'h01 (one transfer, start bit set); all with pwrite=1, penable=1.
REQ-023 POLL SHALL drive paddr CTRL_ADDR, pwrite=0, penable=1, pwdata=0.
REQ-024 Each access SHALL hold paddr/pwdata/pwrite/penable stable until m_pready_i is sampled high; the access completes on that edge.
REQ-025 After every completed access, GAP SHALL drive penable=0, pwrite=0, paddr=0, pwdata=0 for exactly one cycle.
REQ-026 A completed POLL with m_prdata_i[0]=0 SHALL go to FIN; with bit0=1 it SHALL re-poll after GAP unless POLL_MAX reads have completed, in which case it SHALL go to FIN flagged as error.
REQ-027 FIN SHALL last one cycle, pulse done_o[k] (or err_o[k] if flagged, never both), and drop gnt_o[k] on the following edge.
REQ-028 Deassertion of req_i[k] or changes to addr_i/data_i during a transaction SHALL be ignored; the transaction runs to FIN.
REQ-029 A requester still holding req_i after FIN SHALL re-enter arbitration normally, behind any other pending requester.
REQ-030 The poll counter SHALL be at least clog2(POLL_MAX+1) bits wide, clear on every grant, and never wrap.

Reset
REQ-031 With prst_i low, all outputs SHALL be 0 immediately, independent of pclk_i; the state SHALL be IDLE, the round-robin pointer cleared, and latched data and counters zeroed.
REQ-032 Reset during any transaction SHALL abandon it with no done_o/err_o pulse; after release, arbitration restarts per REQ-020/021.

Verification
REQ-033 req_i=01, addr 8'h5A, data 8'h3C, pready tied high, prdata 8'h00 -> writes (00,5A),(10,3C),(20,01), one read of 20, each separated by one GAP cycle; done_o[0] pulses once.
REQ-034 req_i=11 held continuously -> gnt_o sequence 01,10,01,10 with one IDLE cycle between transactions.
REQ-035 pready held low 5 cycles during WR_DATA -> paddr 8'h10, pwdata, and penable stable all 5 cycles; no state advance.
REQ-036 POLL_MAX=4, prdata always 8'h01 -> exactly 4 reads of 20; err_o pulses once; done_o stays 0.
REQ-037 prst_i low during WR_CTRL -> all outputs 0 before the next clock edge; no done/err; after release with req_i=10, requester 1 is granted first.
REQ-038 req_i[0] dropped during WR_ADDR -> transaction completes; done_o[0] pulses.
